dram_rmw_ctrl: RTL

//  Access controller (initiator) for the single-port sync-read data RAM (ram_sync_read_d1 style).
//  - Accepts read and byte-masked write requests over a valid/ready handshake.
//  - Drives the RAM addr/din/we bus and accounts for its 1-cycle read latency.
//  - The RAM writes whole words only, so partial writes run as read-modify-write.
//  - Sits between cache write-hit/byte-check logic and the data RAM.

---
 rtl/dram_rmw_ctrl_if.sv | 34 +++
 rtl/dram_rmw_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dram_rmw_ctrl_if.sv
// Request/response and RAM-side bus of the data-RAM access controller.
// slave: controller view. master: environment view (requester plus RAM).
interface dram_rmw_ctrl_if #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 32
);
    localparam int unsigned BEWIDTH = DWIDTH / 8;

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [AWIDTH-1:0]  req_addr;
    logic [DWIDTH-1:0]  req_wdata;
    logic [BEWIDTH-1:0] req_be;

    logic               rsp_valid;
    logic               rsp_we;
    logic [DWIDTH-1:0]  rsp_rdata;

    logic [AWIDTH-1:0]  ram_addr;
    logic [DWIDTH-1:0]  ram_din;
    logic               ram_we;
    logic [DWIDTH-1:0]  ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, ram_dout,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, ram_addr, ram_din, ram_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, ram_dout,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/dram_rmw_ctrl.sv
// Access controller for a single-port, 1-cycle sync-read data RAM.
// Byte-masked writes are run as read-modify-write since the RAM only writes whole words.
// Optional feature macro: RMW_FULLWR_SKIP_EN -- full-mask writes skip the RAM read
// (IDLE -> WR). When undefined, every write merges via RD/DATA and the WR state is not built.
module dram_rmw_ctrl #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    dram_rmw_ctrl_if.slave bus
);
    localparam int unsigned BEWIDTH = DWIDTH / 8;

`ifdef RMW_FULLWR_SKIP_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StRd = 2'd1, StData = 2'd2, StWr = 2'd3} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StRd = 2'd1, StData = 2'd2} state_e;
`endif

    state_e             state_q, state_d;
    logic [AWIDTH-1:0]  a_q, a_d;
    logic [DWIDTH-1:0]  d_q, d_d;
    logic [BEWIDTH-1:0] be_q, be_d;
    logic               we_q, we_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_we_q, rsp_we_d;
    logic [DWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic [DWIDTH-1:0]  merged;
    logic [DWIDTH-1:0]  ram_din_c;
    logic               ram_we_c;
    logic               req_ready_c;

    // Byte merge of latched write data over the word just read from the RAM.
    always_comb begin
        merged = bus.ram_dout;
        for (int unsigned i = 0; i < BEWIDTH; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = d_q[8*i +: 8];
            end
        end
    end

    // Next-state, request latching and RAM/response drive.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        be_d        = be_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_c = 1'b0;
        ram_din_c   = '0;
        ram_we_c    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    a_d  = bus.req_addr;
                    d_d  = bus.req_wdata;
                    be_d = bus.req_be;
                    we_d = bus.req_we;
`ifdef RMW_FULLWR_SKIP_EN
                    if (bus.req_we && (&bus.req_be)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
`else
                    state_d = StRd;
`endif
                end
            end
            // RAM samples a_q on the edge leaving this state.
            StRd: begin
                state_d = StData;
            end
            // ram_dout now holds mem[a_q]; writes store the merged word back.
            StData: begin
                if (we_q) begin
                    ram_din_c   = merged;
                    ram_we_c    = 1'b1;
                    rsp_rdata_d = merged;
                end else begin
                    rsp_rdata_d = bus.ram_dout;
                end
                rsp_valid_d = 1'b1;
                rsp_we_d    = we_q;
                state_d     = StIdle;
            end
`ifdef RMW_FULLWR_SKIP_EN
            StWr: begin
                ram_din_c   = d_q;
                ram_we_c    = 1'b1;
                rsp_rdata_d = d_q;
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b1;
                state_d     = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            d_q         <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            be_q        <= be_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_addr  = a_q;
    assign bus.ram_din   = ram_din_c;
    // Gated so an in-flight write can never land on a reset edge.
    assign bus.ram_we    = ram_we_c & ~reset;
endmodule
